// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

  // Frame length field width (word count N, little-endian on the wire).
  localparam int LEN_W          = 16;
  // Stream bytes per assembled 32-bit instruction.
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready channel feeding the instruction loader.
// Latency: n/a (wires only).
// Backpressure: the slave drives in_ready; a byte moves when in_valid && in_ready.
// Ports: in_data (8b byte), in_valid (producer has a byte), in_ready (consumer takes it).
interface instr_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/byte_packer.sv
// Assembles four stream bytes into one 32-bit little-endian word.
// Latency: word_ready/word_dat are combinational on the 4th byte (0 cycles).
// Backpressure: none; the caller only asserts byte_vld on accepted bytes.
// Ports: clk, rst (async active-low), clr (sync clear), byte_vld/byte_dat in,
//        word_ready pulse and word_dat out.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_ready,
  output logic [31:0] word_dat
);

  logic [1:0]  cnt;
  // Holds the three earlier bytes of the current word; the oldest byte
  // drifts down to [7:0] as newer bytes are shifted in at the top.
  logic [23:0] low;

  assign word_ready = byte_vld && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word_dat   = {byte_dat, low};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      low <= '0;
    end else if (clr) begin
      cnt <= '0;
      low <= '0;
    end else if (byte_vld) begin
      // 2-bit counter wraps to 0 after the 4th byte of each word.
      cnt <= cnt + 2'd1;
      low <= {byte_dat, low[23:8]};
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a framed byte image (len, words, XOR checksum) into instruction memory.
// Latency: memory write 1 cycle after a word's 4th byte; status 1 cycle after CHK.
// Backpressure: in_ready is high only while a frame is expected; one byte per cycle.
// Ports: clk, rst (async active-low), stream (byte channel, slave side),
//        restart, mem_we/mem_addr/mem_wdata, core_rst, load_done, load_err.
module instr_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
)
(
  input  logic              clk,
  input  logic              rst,
  instr_loader_if.slave     stream,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  loader_state_t    state;
  logic             in_ready_q;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_idx;
  logic [7:0]       xor_acc;

  logic             accept;
  logic [LEN_W-1:0] len_full;
  logic             do_restart;
  logic             word_ready;
  logic [31:0]      word_dat;

  assign stream.in_ready = in_ready_q;
  // in_ready_q only ever sits high in LEN_LO/LEN_HI/DATA/CHECK, so it
  // doubles as the "accepting" state qualifier.
  assign accept     = stream.in_valid && in_ready_q;
  assign len_full   = {stream.in_data, len_lo};
  assign do_restart = restart && ((state == DONE) || (state == ERROR));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (do_restart),
    .byte_vld   (accept && (state == DATA)),
    .byte_dat   (stream.in_data),
    .word_ready (word_ready),
    .word_dat   (word_dat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      in_ready_q <= 1'b0;
      len_lo     <= '0;
      len_q      <= '0;
      word_idx   <= '0;
      xor_acc    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          state      <= LEN_LO;
          in_ready_q <= 1'b1;
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= stream.in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            // Reject before any write so the word index can never wrap.
            if ((len_full == '0) || (len_full > LEN_W'(DEPTH))) begin
              state      <= ERROR;
              load_err   <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              len_q    <= len_full;
              word_idx <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            xor_acc <= xor_acc ^ stream.in_data;
            if (word_ready) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx[ADDR_W-1:0];
              mem_wdata <= word_dat;
              word_idx  <= word_idx + LEN_W'(1);
              if (word_idx == (len_q - LEN_W'(1))) begin
                state <= CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (stream.in_data == xor_acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_rst  <= 1'b0;
            end else begin
              state    <= ERROR;
              load_err <= 1'b1;
            end
          end
        end
        DONE, ERROR: begin
          if (restart) begin
            state      <= LEN_LO;
            in_ready_q <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            xor_acc    <= '0;
            word_idx   <= '0;
            core_rst   <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random frames against a byte-level model.
// Latency: n/a.
// Backpressure: driver holds in_valid until in_ready is seen, with bounded waits.
module tb_instr_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              restart = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst;
  logic              load_done;
  logic              load_err;

  instr_loader_if bus ();

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .stream    (bus),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cnt  = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  int                wr_cyc_q[$];
  logic [7:0]        pl[$];      // payload bytes of the current frame
  logic [7:0]        frame[$];   // complete byte stream to send

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record memory writes and accepted bytes away from the edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.in_valid && bus.in_ready) acc_cnt++;
  end

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    acc_cnt = 0;
  endtask

  // Model: word i is payload bytes 4i..4i+3, first byte least significant.
  function automatic logic [31:0] exp_word(input int i);
    return {pl[4*i+3], pl[4*i+2], pl[4*i+1], pl[4*i]};
  endfunction

  // Number of write-log discrepancies versus the model for an n-word image.
  function automatic int write_errors(input int n);
    int e;
    int lim;
    e   = (wr_data_q.size() != n) ? 1 : 0;
    lim = (wr_data_q.size() < n) ? wr_data_q.size() : n;
    for (int i = 0; i < lim; i++) begin
      if (wr_addr_q[i] !== ADDR_W'(i)) e++;
      if (wr_data_q[i] !== exp_word(i)) e++;
    end
    return e;
  endfunction

  task automatic make_random(input int n, input logic [7:0] chk_flip);
    logic [7:0] chk;
    logic [15:0] nn;
    chk = 8'h00;
    nn  = 16'(n);
    pl.delete();
    frame.delete();
    for (int i = 0; i < 4 * n; i++) begin
      pl.push_back(8'($urandom));
      chk = chk ^ pl[i];
    end
    frame.push_back(nn[7:0]);
    frame.push_back(nn[15:8]);
    foreach (pl[i]) frame.push_back(pl[i]);
    frame.push_back(chk ^ chk_flip);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max, input bit pulse_restart);
    int g;
    int t;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    bus.in_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    restart      = pulse_restart;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, t);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    restart      = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, input int restart_at);
    foreach (frame[i]) send_byte(frame[i], gap_max, i == restart_at);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checks++;
    if ({core_rst, load_done, load_err, bus.in_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL restart_flags: core_rst/done/err/ready=%b, required 1001",
               {core_rst, load_done, load_err, bus.in_ready});
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++;
    if (mem_addr !== '0) begin failures++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++;
    if (mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++;
    if (core_rst !== 1'b1) begin failures++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
    checks++;
    if ({load_done, load_err} !== 2'b00) begin failures++; $display("FAIL rst_flags: got %b want 00", {load_done, load_err}); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pl    = '{8'h13, 8'h01, 8'hA0, 8'h00, 8'h93, 8'h01, 8'h40, 8'h01};
    frame = '{8'h02, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h93, 8'h01, 8'h40, 8'h01, 8'h61};
    send_frame(0, -1);
    checks++;
    if ({load_done, core_rst, load_err, bus.in_ready} !== 4'b1000) begin
      failures++;
      $display("FAIL b2b_status: done/core_rst/err/ready=%b want 1000", {load_done, core_rst, load_err, bus.in_ready});
    end
    checks++;
    if (wr_data_q.size() !== 2) begin
      failures++;
      $display("FAIL b2b_write_count: got %0d want 2", wr_data_q.size());
    end else begin
      checks++;
      if (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h00A00113) begin
        failures++; $display("FAIL b2b_word0: got %h@%0d want 00a00113@0", wr_data_q[0], wr_addr_q[0]);
      end
      checks++;
      if (wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'h01400193) begin
        failures++; $display("FAIL b2b_word1: got %h@%0d want 01400193@1", wr_data_q[1], wr_addr_q[1]);
      end
      checks++;
      if (wr_cyc_q[1] - wr_cyc_q[0] !== 4) begin
        failures++; $display("FAIL b2b_write_spacing: got %0d cycles want 4", wr_cyc_q[1] - wr_cyc_q[0]);
      end
    end
  endtask

  task automatic test_bad_checksum();
    do_restart();
    clear_mon();
    frame[frame.size() - 1] = 8'h60;
    send_frame(0, -1);
    checks++;
    if ({load_err, core_rst, load_done} !== 3'b110) begin
      failures++; $display("FAIL badchk_status: err/core_rst/done=%b want 110", {load_err, core_rst, load_done});
    end
    checks++;
    if (write_errors(2) !== 0) begin
      failures++; $display("FAIL badchk_writes: %0d discrepancies want 0", write_errors(2));
    end
    do_restart();
    clear_mon();
    make_random(3, 8'h00);
    send_frame(0, -1);
    checks++;
    if ({load_done, core_rst, load_err} !== 3'b100) begin
      failures++; $display("FAIL reload_status: done/core_rst/err=%b want 100", {load_done, core_rst, load_err});
    end
    checks++;
    if (write_errors(3) !== 0) begin
      failures++; $display("FAIL reload_writes: %0d discrepancies want 0", write_errors(3));
    end
  endtask

  task automatic test_bad_length();
    logic [15:0] lens[2];
    lens[0] = 16'h0000;
    lens[1] = 16'h0101;
    for (int k = 0; k < 2; k++) begin
      do_restart();
      clear_mon();
      send_byte(lens[k][7:0], 0, 1'b0);
      send_byte(lens[k][15:8], 0, 1'b0);
      checks++;
      if ({load_err, bus.in_ready, core_rst} !== 3'b101) begin
        failures++; $display("FAIL badlen_%h_status: err/ready/core_rst=%b want 101", lens[k], {load_err, bus.in_ready, core_rst});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (wr_data_q.size() !== 0) begin
        failures++; $display("FAIL badlen_%h_writes: got %0d want 0", lens[k], wr_data_q.size());
      end
    end
  endtask

  task automatic test_gaps();
    do_restart();
    clear_mon();
    make_random(1, 8'h00);
    send_frame(3, -1);
    checks++;
    if (acc_cnt !== 7) begin failures++; $display("FAIL gaps_accept_count: got %0d want 7", acc_cnt); end
    checks++;
    if (write_errors(1) !== 0) begin failures++; $display("FAIL gaps_write: %0d discrepancies want 0", write_errors(1)); end
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %b want 1", load_done); end
  endtask

  task automatic test_reset_mid_frame();
    do_restart();
    clear_mon();
    make_random(2, 8'h00);
    for (int i = 0; i < 7; i++) send_byte(frame[i], 0, 1'b0);
    rst = 1'b0;
    #2;
    checks++;
    if ({bus.in_ready, mem_we, core_rst, load_done, load_err} !== 5'b00100 ||
        mem_addr !== '0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL midrst_outputs: ready/we/core_rst/done/err=%b addr=%h wdata=%h want 00100/0/0",
               {bus.in_ready, mem_we, core_rst, load_done, load_err}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_mon();
    make_random(1, 8'h00);
    send_frame(0, -1);
    checks++;
    if (write_errors(1) !== 0) begin
      failures++; $display("FAIL midrst_new_word: %0d discrepancies want 0", write_errors(1));
    end
    checks++;
    if (load_done !== 1'b1) begin failures++; $display("FAIL midrst_done: got %b want 1", load_done); end
  endtask

  task automatic test_full_image();
    do_restart();
    clear_mon();
    make_random(DEPTH, 8'h00);
    send_frame(0, 2 + 100);
    checks++;
    if (write_errors(DEPTH) !== 0) begin
      failures++; $display("FAIL full_writes: %0d discrepancies want 0", write_errors(DEPTH));
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[wr_addr_q.size() - 1] !== 8'd255) begin
      failures++; $display("FAIL full_last_addr: writes=%0d want last addr 255", wr_addr_q.size());
    end
    checks++;
    if (wr_cyc_q.size() != DEPTH || wr_cyc_q[DEPTH - 1] - wr_cyc_q[0] !== 4 * (DEPTH - 1)) begin
      failures++; $display("FAIL full_no_bubbles: writes=%0d want %0d at 4-cycle spacing", wr_cyc_q.size(), DEPTH);
    end
    checks++;
    if ({load_done, core_rst, load_err} !== 3'b100) begin
      failures++; $display("FAIL full_status: done/core_rst/err=%b want 100", {load_done, core_rst, load_err});
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_bad_checksum();
    test_bad_length();
    test_gaps();
    test_reset_mid_frame();
    test_full_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
